// File: rtl/shift_serdes.sv
// Full-duplex shift-register SERDES: a PISO serializer with a load handshake and
// gapless word streaming, plus an independent SIPO deserializer with a word strobe.
module shift_serdes #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_load,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             tx_done,
  input  logic             ser_in,
  input  logic             ser_in_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] rx_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} tx_state_t;

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] tx_sreg;
  logic [CNT_W-1:0] tx_cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit      = (state == SHIFT) && (tx_cnt == LAST);
  assign tx_ready      = (state == IDLE) || last_bit;
  assign accept        = tx_load && tx_ready;
  assign ser_out_valid = (state == SHIFT);
  assign ser_out       = (state == SHIFT) && (LSB_FIRST ? tx_sreg[0] : tx_sreg[WIDTH-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A load on the final-bit cycle overrides the shift, giving a gapless stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_sreg <= '0;
      tx_cnt  <= '0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_done <= last_bit;
      if (accept) begin
        tx_sreg <= tx_data;
        tx_cnt  <= '0;
      end else if (state == SHIFT) begin
        tx_sreg <= LSB_FIRST ? {1'b0, tx_sreg[WIDTH-1:1]} : {tx_sreg[WIDTH-2:0], 1'b0};
        tx_cnt  <= last_bit ? '0 : tx_cnt + CNT_W'(1);
      end
    end
  end

  logic [WIDTH-1:0] rx_sreg, rx_shift;

  assign rx_shift = LSB_FIRST ? {ser_in, rx_sreg[WIDTH-1:1]} : {rx_sreg[WIDTH-2:0], ser_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sreg  <= '0;
      rx_count <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ser_in_valid) begin
        rx_sreg <= rx_shift;
        if (rx_count == LAST) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
          rx_count <= '0;
        end else begin
          rx_count <= rx_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_serdes.sv
// Bench for shift_serdes: an LSB-first instance against a word/bit-queue model
// (directed plus random), and an MSB-first instance in external loopback.
module tb_shift_serdes;
  localparam int W = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, tx_load, ser_in, ser_in_valid;
  logic [W-1:0]  tx_data;
  logic          tx_ready, ser_out, ser_out_valid, tx_done, rx_valid;
  logic [W-1:0]  rx_data;
  logic [CW-1:0] rx_count;

  shift_serdes #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .tx_load(tx_load), .tx_data(tx_data), .tx_ready(tx_ready),
    .ser_out(ser_out), .ser_out_valid(ser_out_valid), .tx_done(tx_done),
    .ser_in(ser_in), .ser_in_valid(ser_in_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_count(rx_count));

  logic          m_tx_load, m_tx_ready, m_ser, m_ser_valid, m_tx_done, m_rx_valid;
  logic [W-1:0]  m_tx_data, m_rx_data;
  logic [CW-1:0] m_rx_count;

  shift_serdes #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .tx_load(m_tx_load), .tx_data(m_tx_data), .tx_ready(m_tx_ready),
    .ser_out(m_ser), .ser_out_valid(m_ser_valid), .tx_done(m_tx_done),
    .ser_in(m_ser), .ser_in_valid(m_ser_valid), .rx_data(m_rx_data), .rx_valid(m_rx_valid),
    .rx_count(m_rx_count));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: the word in flight plus the index of the bit on the wire; RX keeps a bit queue.
  logic         m_busy = 1'b0;
  int           m_pos = 0;
  logic [W-1:0] m_word = '0;
  logic         e_done = 1'b0, e_rxv = 1'b0;
  logic [W-1:0] e_rxd = '0;
  logic         rxq[$];

  task automatic step(input logic rst, input logic ld, input logic [W-1:0] d,
                      input logic siv, input logic si);
    logic acc;
    reset = rst; tx_load = ld; tx_data = d; ser_in_valid = siv; ser_in = si;
    acc = ld && (!m_busy || m_pos == W - 1);
    @(posedge clk); #1;
    if (rst) begin
      m_busy = 1'b0; m_pos = 0; e_done = 1'b0; e_rxv = 1'b0; e_rxd = '0;
      rxq.delete();
    end else begin
      e_done = m_busy && (m_pos == W - 1);
      if (m_busy && m_pos != W - 1) m_pos++;
      else if (acc) begin m_busy = 1'b1; m_word = d; m_pos = 0; end
      else m_busy = 1'b0;
      e_rxv = 1'b0;
      if (siv) begin
        rxq.push_back(si);
        if (rxq.size() == W) begin
          for (int i = 0; i < W; i++) e_rxd[i] = rxq[i];
          e_rxv = 1'b1;
          rxq.delete();
        end
      end
    end
    chk("tx_ready", 32'(tx_ready), 32'(!m_busy || m_pos == W - 1));
    chk("ser_out_valid", 32'(ser_out_valid), 32'(m_busy));
    chk("ser_out", 32'(ser_out), 32'(m_busy ? m_word[m_pos] : 1'b0));
    chk("tx_done", 32'(tx_done), 32'(e_done));
    chk("rx_valid", 32'(rx_valid), 32'(e_rxv));
    chk("rx_data", 32'(rx_data), 32'(e_rxd));
    chk("rx_count", 32'(rx_count), 32'(rxq.size()));
  endtask

  logic [7:0] stream;
  logic       gap_v[7] = '{1, 0, 1, 0, 0, 1, 1};
  logic       gap_b[7] = '{1, 0, 0, 0, 0, 1, 1};

  initial begin
    m_tx_load = 1'b0; m_tx_data = '0;

    // reset, then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

    // single word 0110, explicit serial trace too
    step(0, 1, 4'b0110, 0, 0);
    stream = '0;
    for (int i = 0; i < 4; i++) begin stream[i] = ser_out; step(0, 0, 0, 0, 0); end
    chk("single_stream", 32'(stream[3:0]), 32'h6);
    step(0, 0, 0, 0, 0);

    // back-to-back 6 then A, load on the final-bit cycle
    step(0, 1, 4'h6, 0, 0);
    stream = '0;
    for (int i = 0; i < 8; i++) begin
      stream[i] = ser_out && ser_out_valid;
      step(0, (i == 3), 4'hA, 0, 0);
    end
    chk("b2b_stream", 32'(stream), 32'hA6);
    step(0, 0, 0, 0, 0);

    // RX with valid gaps: bits 1,0,1,1 -> 1101
    for (int i = 0; i < 7; i++) step(0, 0, 0, gap_v[i], gap_b[i]);
    chk("gap_word", 32'(rx_data), 32'hD);

    // reset after 2 TX and 2 RX bits; ignored load mid-word on the fresh word
    step(0, 1, 4'hF, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    chk("rst_rx_count", 32'(rx_count), 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 4'h5, 1, 1);
    step(0, 1, 4'hA, 1, 0);
    step(0, 1, 4'hA, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("fresh_rx", 32'(rx_data), 32'h5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(63) == 0), ($urandom_range(2) == 0), W'($urandom),
           $urandom_range(1), $urandom_range(1));
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // MSB-first loopback: 9 then 3
    @(negedge clk); m_tx_load = 1'b1; m_tx_data = 4'h9;
    @(posedge clk); #1; m_tx_load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("lb_rx_count", 32'(m_rx_count), 32'(k % 4));
      chk("lb_rx_valid", 32'(m_rx_valid), 32'(k % 4 == 0));
      chk("lb_tx_done", 32'(m_tx_done), 32'(k % 4 == 0));
      if (k == 4) chk("lb_word0", 32'(m_rx_data), 32'h9);
      if (k == 8) chk("lb_word1", 32'(m_rx_data), 32'h3);
      if (k == 3) begin
        chk("lb_ready_last", 32'(m_tx_ready), 32'h1);
        m_tx_load = 1'b1; m_tx_data = 4'h3;
      end else m_tx_load = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_serdes.md
Name: shift_serdes

Overview:
- Parametrised full-duplex shift-register block that generalises the fixed 4-bit serial-in/serial-out chain.
- The TX half is a parallel-in/serial-out serializer with a load handshake and back-to-back word streaming.
- The RX half is a serial-in/parallel-out deserializer with a per-bit valid and a word-complete strobe.
- Bit order is selectable. Used wherever a parallel word must cross a 1-bit link inside the design.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- LSB_FIRST, 1, 1 = bit 0 shifted first on both TX and RX; 0 = bit WIDTH-1 first.
- CNT_W, $clog2(WIDTH+1), width of the bit counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_load  in  1  request to load tx_data into the serializer.
- tx_data  in  WIDTH  parallel word to serialize.
- tx_ready  out  1  serializer can accept tx_load this cycle.
- ser_out  out  1  serial data out.
- ser_out_valid  out  1  ser_out carries a valid bit this cycle.
- tx_done  out  1  one-cycle pulse after the last bit of a word is presented.
- ser_in  in  1  serial data in.
- ser_in_valid  in  1  ser_in is sampled on this edge.
- rx_data  out  WIDTH  last completed deserialized word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_count  out  CNT_W  bits of the current RX word received so far (0..WIDTH-1).

Behaviour:
- Reset (reset is synchronous, active-high; clock is clk) clears the following:
  - tx_ready=1, ser_out=0, ser_out_valid=0, tx_done=0.
  - rx_data=0, rx_valid=0, rx_count=0.
  - TX FSM goes to IDLE. Internal shift registers and counters are cleared.
  - Reset mid-word discards the partial TX and RX words; no tx_done or rx_valid is produced for them.
- TX FSM states:
  - IDLE: ser_out_valid=0 and ser_out=0.
  - SHIFT: one bit per cycle, ser_out_valid=1.
- tx_ready is high in IDLE, and in SHIFT only during the cycle presenting the final bit (tx_cnt==WIDTH-1).
- A load is accepted on an edge where tx_load=1 and tx_ready=1:
  - The shift register captures tx_data, tx_cnt=0, state=SHIFT.
  - The first bit appears on ser_out in the cycle after the accepting edge. Latency is 1 cycle, and a word occupies exactly WIDTH cycles.
- Bit order:
  - LSB_FIRST=1: ser_out = sreg[0], and the register shifts right.
  - LSB_FIRST=0: ser_out = sreg[WIDTH-1], and the register shifts left.
- At the edge ending the final-bit cycle:
  - With a new load accepted: reload and stay in SHIFT. The stream has no gap and ser_out_valid stays 1.
  - Without a new load: return to IDLE.
  - In both cases tx_done=1 for the following cycle only.
- tx_load while tx_ready=0 is ignored. It is not queued, and tx_data is not sampled.
- RX: on each edge with ser_in_valid=1, the bit is shifted into the RX register in the configured order and rx_count increments.
  - LSB_FIRST=1: the first bit lands in rx_data[0].
- On the edge receiving the WIDTH-th bit:
  - rx_data is updated to the full word and rx_valid=1 for the next cycle.
  - rx_count wraps to 0.
- rx_data holds until the next complete word. Gaps in ser_in_valid pause assembly without loss.
- TX and RX are fully independent. They may be looped back externally (ser_in=ser_out, ser_in_valid=ser_out_valid) with no extra logic.
- Counter widths are exact. There is no overflow state, because the counters wrap at WIDTH.

Test Plan:
- Reset, then hold reset=0 with tx_load=0 for 5 cycles:
  - All outputs equal their reset values.
  - tx_ready=1, ser_out_valid=0.
- WIDTH=4, LSB_FIRST=1, tx_data=4'b0110 loaded once:
  - ser_out is 0,1,1,0 over 4 cycles starting 1 cycle after the load edge, with ser_out_valid=1.
  - tx_done is pulsed in cycle 5, then the block returns to IDLE.
- Back-to-back: load 4'h6, then 4'hA on the final-bit cycle:
  - 8 contiguous valid bits 0,1,1,0,0,1,0,1.
  - tx_done pulses twice; no gap.
- Loopback with LSB_FIRST=0, sending 4'h9 then 4'h3:
  - rx_valid pulses twice, rx_data=4'h9 then 4'h3, each matching the sent word.
  - rx_count sequence is 1,2,3,0 per word.
- RX with ser_in_valid gaps (bits 1,_,0,_,_,1,1, LSB_FIRST=1):
  - Single rx_valid pulse, rx_data=4'b1101.
- Reset asserted after 2 TX and 2 RX bits of a word:
  - No tx_done or rx_valid is produced; rx_count=0.
  - A subsequent fresh word (4'h5) transfers correctly.
  - tx_load with tx_ready=0 mid-word is ignored: the output stream is unchanged.
